// File: rtl/tmds_pkg.sv
// Shared TMDS types and constants: control symbols, symbol/q_m typedefs, disparity width.
package tmds_pkg;

  localparam int unsigned DISP_W = 5;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [8:0] tmds_qm_t;

  localparam tmds_sym_t CTRL_SYM_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_SYM_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_SYM_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_SYM_11 = 10'b1010101011;

  function automatic tmds_sym_t ctrl_symbol(input logic [1:0] ctrl);
    tmds_sym_t sym;
    unique case (ctrl)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_if.sv
// Pixel-side bundle of the TMDS encoder: shared de, per-lane bytes/control bits, encoded symbols.
interface tmds_if #(
  parameter int unsigned CHANNELS = 3
);
  logic                   i_de;
  logic [CHANNELS*8-1:0]  i_data;
  logic [CHANNELS*2-1:0]  i_ctrl;
  logic [CHANNELS*10-1:0] o_tmds;
  logic                   o_de;

  modport master (
    output i_de,
    output i_data,
    output i_ctrl,
    input  o_tmds,
    input  o_de
  );

  modport slave (
    input  i_de,
    input  i_data,
    input  i_ctrl,
    output o_tmds,
    output o_de
  );
endinterface

// File: rtl/tmds_tm_stage.sv
// Combinational 8b->9b transition minimisation for one lane, plus popcount of q_m[7:0].
module tmds_tm_stage
  import tmds_pkg::*;
(
  input  logic [7:0] i_data,
  output tmds_qm_t   o_qm,
  output logic [3:0] o_n1
);

  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [7:0] w_q;

  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) begin
      w_n1d = w_n1d + 4'(i_data[i]);
    end
    w_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !i_data[0]);

    w_q    = '0;
    w_q[0] = i_data[0];
    for (int i = 1; i < 8; i++) begin
      w_q[i] = w_xnor ? ~(w_q[i-1] ^ i_data[i]) : (w_q[i-1] ^ i_data[i]);
    end
    // q_m[8] flags XOR mode so the decoder knows which inversion to undo
    o_qm = {~w_xnor, w_q};

    o_n1 = '0;
    for (int i = 0; i < 8; i++) begin
      o_n1 = o_n1 + 4'(w_q[i]);
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// Multi-lane pipelined TMDS encoder, 2-cycle latency.
// Optional `TMDS_DISPARITY_OUT_EN exposes each lane's running disparity as o_disparity.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNELS = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  tmds_if.slave bus
`ifdef TMDS_DISPARITY_OUT_EN
  ,
  output logic [CHANNELS*DISP_W-1:0] o_disparity
`endif
);

  logic r_de1;
  logic r_de2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_de1 <= 1'b0;
      r_de2 <= 1'b0;
    end else begin
      r_de1 <= bus.i_de;
      r_de2 <= r_de1;
    end
  end

  assign bus.o_de = r_de2;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    tmds_qm_t                  w_qm;
    logic [3:0]                w_n1;
    tmds_qm_t                  r_qm;
    logic [3:0]                r_n1;
    logic [1:0]                r_ctrl;
    tmds_sym_t                 r_sym;
    tmds_sym_t                 w_sym;
    logic signed [DISP_W-1:0]  r_cnt;
    logic signed [DISP_W-1:0]  w_cnt;
    logic signed [DISP_W-1:0]  w_bal;

    tmds_tm_stage u_tm (
      .i_data (bus.i_data[8*k +: 8]),
      .o_qm   (w_qm),
      .o_n1   (w_n1)
    );

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_qm   <= '0;
        r_n1   <= '0;
        r_ctrl <= '0;
        r_sym  <= CTRL_SYM_00;
        r_cnt  <= '0;
      end else begin
        r_qm   <= w_qm;
        r_n1   <= w_n1;
        r_ctrl <= bus.i_ctrl[2*k +: 2];
        r_sym  <= w_sym;
        r_cnt  <= w_cnt;
      end
    end

    // n1 - n0 = 2*n1 - 8, always within -8..+8
    assign w_bal = DISP_W'({1'b0, r_n1, 1'b0} - 6'd8);

    always_comb begin
      w_sym = r_sym;
      w_cnt = r_cnt;
      if (!r_de1) begin
        w_sym = ctrl_symbol(r_ctrl);
        w_cnt = '0;
      end else if ((r_cnt == '0) || (r_n1 == 4'd4)) begin
        w_sym = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
      end else if ((!r_cnt[DISP_W-1] && (r_n1 > 4'd4)) ||
                   (r_cnt[DISP_W-1] && (r_n1 < 4'd4))) begin
        w_sym = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt = r_cnt - w_bal + (r_qm[8] ? 5'sd2 : 5'sd0);
      end else begin
        w_sym = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt = r_cnt + w_bal - (r_qm[8] ? 5'sd0 : 5'sd2);
      end
    end

    assign bus.o_tmds[10*k +: 10] = r_sym;
`ifdef TMDS_DISPARITY_OUT_EN
    assign o_disparity[DISP_W*k +: DISP_W] = r_cnt;
`endif
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: integer reference model plus literal spot checks.
module tb_tmds_encoder;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmds_if #(.CHANNELS(NCH)) bus ();

`ifdef TMDS_DISPARITY_OUT_EN
  logic [NCH*5-1:0] disp;
`endif

  tmds_encoder #(.CHANNELS(NCH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef TMDS_DISPARITY_OUT_EN
    ,
    .o_disparity (disp)
`endif
  );

  logic [7:0] p_data;
  logic [8:0] p_qm;
  logic [3:0] p_n1;

  tmds_tm_stage u_probe (
    .i_data (p_data),
    .o_qm   (p_qm),
    .o_n1   (p_n1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  logic [9:0] csym [4];
  initial begin
    csym[0] = 10'b1101010100;
    csym[1] = 10'b0010101011;
    csym[2] = 10'b0101010100;
    csym[3] = 10'b1010101011;
  end

  // Reference encoder: straight from the DVI rules, integer disparity
  function automatic logic [9:0] ref_encode(input logic [7:0] d, input int cin,
                                            output int cout);
    int       n1d, n1, n0;
    bit       use_xnor;
    bit [8:0] q;
    logic [9:0] s;
    n1d = $countones(d);
    use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !use_xnor;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == 4) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = cin + (q[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cin > 0 && n1 > 4) || (cin < 0 && n1 < 4)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cout = cin + 2 * int'(q[8]) + (n0 - n1);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cout = cin + (n1 - n0) - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  // Model state: what the first pipeline stage holds, and the expected outputs
  bit         m_valid = 1'b0;
  logic       s1_de;
  logic [7:0] s1_data [NCH];
  logic [1:0] s1_ctrl [NCH];
  int         m_cnt   [NCH];
  logic [9:0] m_exp   [NCH];
  logic       m_exp_de;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_exp_de = 1'b0;
      s1_de    = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_exp[k]   = csym[0];
        m_cnt[k]   = 0;
        s1_data[k] = 8'h00;
        s1_ctrl[k] = 2'b00;
      end
    end else if (m_valid) begin
      m_exp_de = s1_de;
      for (int k = 0; k < NCH; k++) begin
        if (!s1_de) begin
          m_exp[k] = csym[s1_ctrl[k]];
          m_cnt[k] = 0;
        end else begin
          m_exp[k] = ref_encode(s1_data[k], m_cnt[k], m_cnt[k]);
        end
      end
      s1_de = bus.i_de;
      for (int k = 0; k < NCH; k++) begin
        s1_data[k] = bus.i_data[8*k +: 8];
        s1_ctrl[k] = bus.i_ctrl[2*k +: 2];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("o_de", 32'(bus.o_de), 32'(m_exp_de));
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("lane%0d_tmds", k), 32'(bus.o_tmds[10*k +: 10]), 32'(m_exp[k]));
`ifdef TMDS_DISPARITY_OUT_EN
        check($sformatf("lane%0d_cnt", k), 32'(disp[5*k +: 5]), 32'(5'(m_cnt[k])));
        check($sformatf("lane%0d_cnt_bound", k),
              32'(($signed(disp[5*k +: 5]) <= 8) && ($signed(disp[5*k +: 5]) >= -8)), 32'd1);
`endif
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and wait for the next falling edge
  task automatic cyc(input logic r, input logic de, input logic [23:0] d, input logic [5:0] c);
    rst        = r;
    bus.i_de   = de;
    bus.i_data = d;
    bus.i_ctrl = c;
    @(negedge clk);
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  initial begin
    rst        = 1'b1;
    bus.i_de   = 1'($urandom);
    bus.i_data = rnd24();
    bus.i_ctrl = 6'($urandom);

    p_data = 8'b1111_1110;
    #1 check("tm_fe", 32'(p_qm), 32'h000);
    p_data = 8'b0000_0001;
    #1 check("tm_01", 32'(p_qm), 32'h1FF);

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NCH; k++)
        check("reset_sym", 32'(bus.o_tmds[10*k +: 10]), 32'(10'b1101010100));
      check("reset_de", 32'(bus.o_de), 32'd0);
`ifdef TMDS_DISPARITY_OUT_EN
      check("reset_cnt", 32'(disp), 32'd0);
`endif
      cyc(1'b1, 1'($urandom), rnd24(), 6'($urandom));
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, rnd24(), 6'b0);

    // DC balance: two zero bytes on lane 0 after a control period
    cyc(1'b0, 1'b1, {16'h0000, 8'h00}, 6'b0);
    cyc(1'b0, 1'b1, {16'h0000, 8'h00}, 6'b0);
    check("dc_first", 32'(bus.o_tmds[9:0]), 32'h100);
`ifdef TMDS_DISPARITY_OUT_EN
    check("dc_cnt_first", 32'(disp[4:0]), 32'(5'b11000));
`endif
    cyc(1'b0, 1'b0, rnd24(), 6'b0);
    check("dc_second", 32'(bus.o_tmds[9:0]), 32'h3FF);
`ifdef TMDS_DISPARITY_OUT_EN
    check("dc_cnt_second", 32'(disp[4:0]), 32'(5'b00010));
`endif

    for (int i = 0; i < 6; i++) begin
      logic [1:0] c;
      if (i >= 2) begin
        for (int k = 0; k < NCH; k++)
          check($sformatf("ctrl_sym%0d", i - 2), 32'(bus.o_tmds[10*k +: 10]),
                32'(csym[i-2]));
      end
      c = 2'(i);
      cyc(1'b0, 1'b0, rnd24(), {c, c, c});
    end

    // Lane independence: constant extremes on lanes 0/1, random on lane 2
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, {8'($urandom), 8'hFF, 8'h00}, 6'($urandom));

    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, rnd24(), 6'($urandom));
    cyc(1'b0, 1'b0, rnd24(), 6'($urandom));
    cyc(1'b0, 1'b1, rnd24(), 6'($urandom));
`ifdef TMDS_DISPARITY_OUT_EN
    check("de_drop_cnt", 32'(disp), 32'd0);
`endif
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, rnd24(), 6'($urandom));

    cyc(1'b1, 1'b1, rnd24(), 6'($urandom));
    for (int k = 0; k < NCH; k++)
      check("midreset_sym", 32'(bus.o_tmds[10*k +: 10]), 32'(10'b1101010100));
    check("midreset_de", 32'(bus.o_de), 32'd0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, rnd24(), 6'($urandom));
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'($urandom_range(0, 3) != 0), rnd24(), 6'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
